// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and the cyclic priority search for rr_arbiter_4.
package rr_arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Scan base, base+1, ... (mod N_REQ); first set bit wins.
   function automatic logic [IDX_W-1:0] next_winner(
      input logic [N_REQ-1:0] req,
      input logic [IDX_W-1:0] base
   );
      logic [IDX_W-1:0] w;
      logic [IDX_W-1:0] c;
      logic             f;
      w = base;
      f = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         c = base + IDX_W'(i);
         if (!f && req[c]) begin
            w = c;
            f = 1'b1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/decoder_2x4.sv
// Binary to one-hot decoder, 2 bits in, 4 lines out.
module decoder_2x4 (
   input  logic [1:0] in_i,
   output logic [3:0] out_o
);

   assign out_o = 4'b0001 << in_i;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered owner index.
// Define RR_ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles.
module rr_arbiter_4
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
      $error("rr_arbiter_4: MAX_HOLD/CNT_W out of range");
   end

   state_t           state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] idx_q;
   logic             valid_q;
   logic [IDX_W-1:0] idx_inc;
   logic [N_REQ-1:0] own;

   assign idx_inc = idx_q + 1'b1;

   decoder_2x4 u_dec (
      .in_i  (idx_q),
      .out_o (own)
   );

   assign gnt       = own & {N_REQ{valid_q}};
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;

`ifdef RR_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_q;
   logic             preempt_q;
   logic [N_REQ-1:0] others;

   assign others  = req & ~own;
   assign preempt = preempt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q <= GRANT;
                  idx_q   <= next_winner(req, ptr_q);
                  valid_q <= 1'b1;
                  hold_q  <= '0;
               end
            end
            GRANT: begin
               if (!req[idx_q]) begin
                  ptr_q  <= idx_inc;
                  hold_q <= '0;
                  if (|req) begin
                     idx_q <= next_winner(req, idx_inc);
                  end else begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                  end
               end else if (hold_q == CNT_W'(MAX_HOLD - 1) && |others) begin
                  // Owner still wants it, but someone else is waiting: revoke.
                  idx_q     <= next_winner(others, idx_inc);
                  ptr_q     <= idx_inc;
                  hold_q    <= '0;
                  preempt_q <= 1'b1;
               end else if (hold_q != CNT_W'(MAX_HOLD)) begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end
`else
   assign preempt = 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q <= GRANT;
                  idx_q   <= next_winner(req, ptr_q);
                  valid_q <= 1'b1;
               end
            end
            GRANT: begin
               // Release hands over on the same edge when anyone else waits.
               if (!req[idx_q]) begin
                  ptr_q <= idx_inc;
                  if (|req) begin
                     idx_q <= next_winner(req, idx_inc);
                  end else begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed, table-driven checks for rr_arbiter_4.
module tb_rr_arbiter_4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rr_arbiter_4 #(
      .MAX_HOLD (4),
      .CNT_W    (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input logic [3:0] r);
      req = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // req applied, then gnt/idx/valid seen after the next edge
      tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[4]  = '{4'b0011, 4'b0001, 2'd0, 1'b1};
      tbl[5]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
      tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[7]  = '{4'b1111, 4'b0100, 2'd2, 1'b1};
      tbl[8]  = '{4'b1011, 4'b1000, 2'd3, 1'b1};
      tbl[9]  = '{4'b1011, 4'b1000, 2'd3, 1'b1};
      tbl[10] = '{4'b0011, 4'b0001, 2'd0, 1'b1};
      tbl[11] = '{4'b0011, 4'b0001, 2'd0, 1'b1};
      tbl[12] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
      tbl[13] = '{4'b0011, 4'b0010, 2'd1, 1'b1};
      tbl[14] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
      tbl[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

      reset = 1'b1;
      req   = 4'b0000;
      #2;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_vld", int'(gnt_valid), 0);
      chk("rst_idx", int'(gnt_idx), 0);
      chk("rst_pre", int'(preempt), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         tick(tbl[i].req);
         chk($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
         chk($sformatf("tbl%0d_vld", i), int'(gnt_valid), int'(tbl[i].vld));
         chk($sformatf("tbl%0d_pre", i), int'(preempt), 0);
         if (tbl[i].vld)
            chk($sformatf("tbl%0d_idx", i), int'(gnt_idx), int'(tbl[i].idx));
      end

      // All request; each owner releases for one cycle after three.
      do_reset();
      tick(4'b1111);
      chk("rot_first", int'(gnt), 1);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 2; c++) begin
            tick(4'b1111);
            chk($sformatf("rot%0d_hold", k), int'(gnt_idx), k);
            chk($sformatf("rot%0d_vld", k), int'(gnt_valid), 1);
         end
         tick(4'b1111 & ~(4'b0001 << k));
         chk($sformatf("rot%0d_next", k), int'(gnt), 1 << ((k + 1) % 4));
         chk($sformatf("rot%0d_nobub", k), int'(gnt_valid), 1);
      end

      // Asynchronous reset while index 3 owns, ptr left at 3.
      do_reset();
      tick(4'b0100);
      tick(4'b0000);
      tick(4'b1000);
      chk("mid_pre", int'(gnt), 8);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_gnt", int'(gnt), 0);
      chk("mid_vld", int'(gnt_valid), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(4'b1010);
      chk("mid_ptr0", int'(gnt), 2);

`ifdef RR_ARB_TIMEOUT_EN
      do_reset();
      for (int c = 0; c < 12; c++) begin
         tick(4'b0011);
         chk($sformatf("to%0d_gnt", c), int'(gnt), 1 << ((c / 4) % 2));
         chk($sformatf("to%0d_pre", c), int'(preempt),
             (c % 4 == 0 && c > 0) ? 1 : 0);
      end
      do_reset();
      for (int c = 0; c < 10; c++) begin
         tick(4'b0001);
         chk($sformatf("solo%0d_gnt", c), int'(gnt), 1);
         chk($sformatf("solo%0d_pre", c), int'(preempt), 0);
      end
`else
      do_reset();
      for (int c = 0; c < 50; c++) begin
         tick(4'b0011);
         chk($sformatf("hold%0d_gnt", c), int'(gnt), 1);
         chk($sformatf("hold%0d_pre", c), int'(preempt), 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that owns a shared resource and drives a registered one-hot grant.
- The grant bus is produced by decoding the registered 2-bit winner index.
- Sits in front of any 4-way shared datapath, such as a bus, memory port or mux select, so that exactly one requester drives it at a time.
- Grants are held until release; an optional hold-timeout forces fairness under continuous requests.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced rotation (legal 1..255; used only with the timeout feature).
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i] is held high by requester i until it is done.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- gnt_idx  output  2  binary index of the current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout; constant 0 when the feature is compiled out.

Behaviour:
- Reset values (asynchronous, active-high): gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, state=IDLE, priority pointer ptr=0, hold_cnt=0.
- Search function: starting at a base index, scan base, base+1, ... modulo 4 (3 wraps to 0). The first set bit wins.
- Invariant: gnt is always the decode of gnt_idx gated by gnt_valid, so at most one bit is ever set.
- IDLE:
  - If req != 0, the winner is search(ptr).
  - Next edge: state=GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Latency: req sampled high at edge N gives gnt visible after edge N (1-cycle registered).
- GRANT, req[gnt_idx]=1 (no timeout):
  - Grant holds unchanged.
  - hold_cnt increments, saturating at MAX_HOLD.
- GRANT, req[gnt_idx]=0 (release):
  - ptr <= gnt_idx+1 (mod 4).
  - If other requests are pending, hand over on the same edge to search(gnt_idx+1), with no idle bubble, and set hold_cnt=0.
  - Otherwise go to IDLE with gnt=0 and gnt_valid=0.
- Simultaneous requests from IDLE: the lowest index at or above ptr (cyclic) wins. After reset, req=4'b1111 grants index 0.
- A requester that drops req while not owning has no effect. A requester re-raising req right after release waits behind all others (fair rotation).
- Reset mid-grant: all outputs return to reset values immediately (asynchronous), and ptr returns to 0.
- Illegal states of the 2-state FSM recover to IDLE.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt == MAX_HOLD-1 and req has any bit other than gnt_idx set, revoke the grant.
  - Next edge: gnt_idx=search(gnt_idx+1) excluding the current owner, ptr=old gnt_idx+1, hold_cnt=0, preempt=1 for one cycle.
  - If no other requester is pending, the grant stays and hold_cnt saturates.
- Undefined:
  - No counter logic is compiled in and preempt is tied 0.
  - The grant is held indefinitely while req[gnt_idx]=1.

Decomposition:
- Package rr_arb_pkg:
  - typedef for state (IDLE=1'b0, GRANT=1'b1).
  - constants N_REQ=4 and IDX_W=2.
  - search function next_winner(req, base).
- Sub-module: instantiate the team's existing decoder_2x4 to drive gnt from gnt_idx, with its output ANDed with gnt_valid. No other sub-modules.

Test Plan:
- Reset, then req=4'b0100 at cycle 2 -> gnt=4'b0100, gnt_idx=2, gnt_valid=1 from cycle 3; drop req at cycle 6 -> gnt=0 at cycle 7; ptr=3.
- After reset, req=4'b1111 held; each owner drops req for 1 cycle after 3 cycles of grant -> grant order 0,1,2,3,0 with no idle cycle between owners.
- ptr=3 and req=4'b0011 -> index 0 wins (wrap-around); then release -> index 1.
- Assert reset while gnt=4'b1000 mid-cycle -> gnt=0, gnt_valid=0 immediately, before the next clk edge; first grant after reset follows ptr=0.
- With RR_ARB_TIMEOUT_EN and MAX_HOLD=4, req=4'b0011 held -> gnt 0001 for 4 cycles, preempt pulse, gnt 0010 for 4 cycles, and so on; with req=4'b0001 only -> gnt held and preempt stays 0.
- Without the macro, same stimulus req=4'b0011 held for 50 cycles -> gnt stays 4'b0001 throughout and preempt=0.
